// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared widths, defaults and FSM state type for the SNN datapath
package snn_pkg;

    localparam int LANES  = 8;
    localparam int U_W    = 16;
    localparam int B_W    = 8;
    localparam int ADDR_W = 9;
    localparam int SUM_W  = 19;

    localparam int                     DEF_LEAK_SHIFT = 4;
    localparam logic signed [U_W-1:0]  DEF_THRESHOLD  = 16'sd1024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_e;

endpackage

// File: rtl/lif_lane.sv
// rtl/lif_lane.sv - combinational leaky integrate-and-fire update for one neuron
// NEURON_UPDATE_SAT_EN selects clamping instead of wrap when narrowing the 19-bit sum.
module lif_lane
    import snn_pkg::*;
#(
    parameter int                    LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter logic signed [U_W-1:0] THRESHOLD  = DEF_THRESHOLD
) (
    input  logic signed [U_W-1:0] u_i,
    input  logic signed [U_W-1:0] acc_i,
    input  logic signed [B_W-1:0] bias_i,
    output logic signed [U_W-1:0] u_new_o,
    output logic                  spike_o
);

    logic signed [SUM_W-1:0] u_x;
    logic signed [SUM_W-1:0] leak_x;
    logic signed [SUM_W-1:0] acc_x;
    logic signed [SUM_W-1:0] bias_x;
    logic signed [SUM_W-1:0] sum;
    logic signed [U_W-1:0]   narrowed;

    assign u_x    = {{(SUM_W-U_W){u_i[U_W-1]}}, u_i};
    assign acc_x  = {{(SUM_W-U_W){acc_i[U_W-1]}}, acc_i};
    assign bias_x = {{(SUM_W-B_W){bias_i[B_W-1]}}, bias_i};
    assign leak_x = u_x >>> LEAK_SHIFT;
    assign sum    = u_x - leak_x + acc_x + bias_x;

`ifdef NEURON_UPDATE_SAT_EN
    localparam logic signed [SUM_W-1:0] SUM_MAX = 19'sd32767;
    localparam logic signed [SUM_W-1:0] SUM_MIN = -19'sd32768;

    always_comb begin
        narrowed = sum[U_W-1:0];
        if (sum > SUM_MAX) begin
            narrowed = 16'sh7fff;
        end else if (sum < SUM_MIN) begin
            narrowed = 16'sh8000;
        end
    end
`else
    // Two's-complement wrap: the threshold sees the wrapped value.
    assign narrowed = sum[U_W-1:0];
`endif

    assign spike_o = (narrowed >= THRESHOLD);
    assign u_new_o = spike_o ? '0 : narrowed;

endmodule

// File: rtl/neuron_update.sv
// rtl/neuron_update.sv - per-timestep membrane sweep: leak, integrate, fire, write back
// NEURON_UPDATE_SAT_EN (in lif_lane) selects saturating narrowing.
module neuron_update
    import snn_pkg::*;
#(
    parameter int                    N_ROWS     = 128,
    parameter int                    LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter logic signed [U_W-1:0] THRESHOLD  = DEF_THRESHOLD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [6:0]              acc_row_sel,
    input  logic [LANES*U_W-1:0]    acc_in,
    input  logic [LANES*U_W-1:0]    u_read_sram,
    output logic [ADDR_W-1:0]       u_read_sram_addr,
    output logic [LANES*U_W-1:0]    u_write_sram,
    output logic [ADDR_W-1:0]       u_write_sram_addr,
    output logic                    u_write_sram_we,
    input  logic [LANES*B_W-1:0]    b_read_sram,
    output logic [ADDR_W-1:0]       b_read_sram_addr,
    output logic [2*LANES-1:0]      spk_write_sram,
    output logic [ADDR_W-1:0]       spk_write_sram_addr,
    output logic                    spk_write_sram_we
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

    state_e                 state_q;
    logic [ADDR_W-1:0]      row_q;
    logic [ADDR_W-1:0]      row_d;
    logic [LANES-1:0]       spk_even_q;
    logic                   busy_q;
    logic                   done_q;
    logic [LANES*U_W-1:0]   u_wdata_q;
    logic [ADDR_W-1:0]      u_waddr_q;
    logic                   u_we_q;
    logic [2*LANES-1:0]     spk_wdata_q;
    logic [ADDR_W-1:0]      spk_addr_q;
    logic                   spk_we_q;

    logic [LANES*U_W-1:0]   lane_u;
    logic [LANES-1:0]       lane_spk;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lif_lane #(
            .LEAK_SHIFT (LEAK_SHIFT),
            .THRESHOLD  (THRESHOLD)
        ) u_lane (
            .u_i     (u_read_sram[k*U_W +: U_W]),
            .acc_i   (acc_in[k*U_W +: U_W]),
            .bias_i  (b_read_sram[k*B_W +: B_W]),
            .u_new_o (lane_u[k*U_W +: U_W]),
            .spike_o (lane_spk[k])
        );
    end

    assign row_d = row_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            spk_even_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            u_wdata_q   <= '0;
            u_waddr_q   <= '0;
            u_we_q      <= 1'b0;
            spk_wdata_q <= '0;
            spk_addr_q  <= '0;
            spk_we_q    <= 1'b0;
        end else begin
            u_we_q   <= 1'b0;
            spk_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RD;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RD: begin
                    state_q <= S_WR;
                end
                S_WR: begin
                    u_we_q    <= 1'b1;
                    u_waddr_q <= row_q;
                    u_wdata_q <= lane_u;
                    // Even rows park their spikes so the odd row can write a full word.
                    if (row_q[0]) begin
                        spk_we_q    <= 1'b1;
                        spk_wdata_q <= {lane_spk, spk_even_q};
                        spk_addr_q  <= {1'b0, row_q[ADDR_W-1:1]};
                    end else begin
                        spk_even_q <= lane_spk;
                    end
                    if (row_q == LAST_ROW) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        row_q   <= row_d;
                        state_q <= S_RD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign acc_row_sel         = row_q[6:0];
    assign u_read_sram_addr    = row_q;
    assign b_read_sram_addr    = row_q;
    assign u_write_sram        = u_wdata_q;
    assign u_write_sram_addr   = u_waddr_q;
    assign u_write_sram_we     = u_we_q;
    assign spk_write_sram      = spk_wdata_q;
    assign spk_write_sram_addr = spk_addr_q;
    assign spk_write_sram_we   = spk_we_q;

endmodule

// File: tb/tb_neuron_update.sv
// tb/tb_neuron_update.sv - directed self-checking bench for neuron_update
module tb_neuron_update;

    localparam int N_ROWS = 128;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         busy;
    logic         done;
    logic [6:0]   acc_row_sel;
    logic [127:0] acc_in;
    logic [127:0] u_read_sram;
    logic [8:0]   u_read_sram_addr;
    logic [127:0] u_write_sram;
    logic [8:0]   u_write_sram_addr;
    logic         u_write_sram_we;
    logic [63:0]  b_read_sram;
    logic [8:0]   b_read_sram_addr;
    logic [15:0]  spk_write_sram;
    logic [8:0]   spk_write_sram_addr;
    logic         spk_write_sram_we;

    always #5 clk = ~clk;

    neuron_update #(.N_ROWS(N_ROWS)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .acc_row_sel         (acc_row_sel),
        .acc_in              (acc_in),
        .u_read_sram         (u_read_sram),
        .u_read_sram_addr    (u_read_sram_addr),
        .u_write_sram        (u_write_sram),
        .u_write_sram_addr   (u_write_sram_addr),
        .u_write_sram_we     (u_write_sram_we),
        .b_read_sram         (b_read_sram),
        .b_read_sram_addr    (b_read_sram_addr),
        .spk_write_sram      (spk_write_sram),
        .spk_write_sram_addr (spk_write_sram_addr),
        .spk_write_sram_we   (spk_write_sram_we)
    );

    logic [127:0] u_init  [512];
    logic [127:0] u_mem   [512];
    logic [127:0] acc_mem [128];
    logic [63:0]  b_mem   [512];
    logic [15:0]  spk_init[256];
    logic [15:0]  spk_mem [256];
    logic         load_req = 1'b0;
    logic         cnt_clr  = 1'b0;
    int           u_wr_cnt = 0;
    int           spk_wr_cnt = 0;
    int           first_waddr = -1;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [15:0]  exp_u [6][8];

    assign acc_in = acc_mem[acc_row_sel];

    // SRAM models: 1-cycle synchronous read, write on we.
    always @(posedge clk) begin
        u_read_sram <= u_mem[u_read_sram_addr];
        b_read_sram <= b_mem[b_read_sram_addr];
        if (load_req) begin
            for (int i = 0; i < 512; i++) u_mem[i] <= u_init[i];
            for (int i = 0; i < 256; i++) spk_mem[i] <= spk_init[i];
        end
        if (cnt_clr) begin
            u_wr_cnt    <= 0;
            spk_wr_cnt  <= 0;
            first_waddr <= -1;
        end else begin
            if (u_write_sram_we) begin
                u_mem[u_write_sram_addr] <= u_write_sram;
                u_wr_cnt <= u_wr_cnt + 1;
                if (first_waddr < 0) first_waddr <= int'(u_write_sram_addr);
            end
            if (spk_write_sram_we) begin
                spk_mem[spk_write_sram_addr] <= spk_write_sram;
                spk_wr_cnt <= spk_wr_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_mems();
        @(negedge clk);
        load_req = 1'b1;
        cnt_clr  = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic run_sweep(input int mid_start_cyc, output int done_cyc,
                             output int busy_cyc, output int done_cnt);
        done_cyc = -1;
        busy_cyc = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 2*N_ROWS + 10; c++) begin
            @(negedge clk);
            start = (c == mid_start_cyc);
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int  done_cyc, busy_cyc, done_cnt;
        logic seen_busy, seen_done, seen_we;

        for (int r = 0; r < 512; r++) begin
            u_init[r] = '0;
            b_mem[r]  = '0;
        end
        for (int r = 0; r < 128; r++) acc_mem[r] = '0;
        for (int i = 0; i < 256; i++) spk_init[i] = 16'h0000;
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 8; k++) exp_u[r][k] = 16'h0000;

        // Row 0: leak on +160, lane 3 fires (1000-62+100=1038).
        for (int k = 0; k < 8; k++) begin
            u_init[0][16*k +: 16] = 16'd160;
            exp_u[0][k] = 16'd150;
        end
        u_init[0][48 +: 16]  = 16'd1000;
        acc_mem[0][48 +: 16] = 16'd100;
        exp_u[0][3] = 16'd0;
        // Row 1: leak on -160, lane 0 fires.
        for (int k = 0; k < 8; k++) begin
            u_init[1][16*k +: 16] = 16'hff60;
            exp_u[1][k] = 16'hff6a;
        end
        u_init[1][0 +: 16]  = 16'd1000;
        acc_mem[1][0 +: 16] = 16'd100;
        exp_u[1][0] = 16'd0;
        // Row 2: lane 3 just under threshold (968).
        u_init[2][48 +: 16]  = 16'd1000;
        acc_mem[2][48 +: 16] = 16'd30;
        exp_u[2][3] = 16'd968;
        // Row 3: lane 0 overflow, sum 63614.
        u_init[3][0 +: 16]  = 16'h7fff;
        acc_mem[3][0 +: 16] = 16'h7fff;
        b_mem[3][0 +: 8]    = 8'h7f;
`ifdef NEURON_UPDATE_SAT_EN
        exp_u[3][0] = 16'd0;
`else
        exp_u[3][0] = 16'hf87e;
`endif
        // Row 4: bias sign extension and threshold equality.
        b_mem[4][0 +: 8]     = 8'hfb;
        exp_u[4][0] = 16'hfffb;
        acc_mem[4][16 +: 16] = 16'd924;
        b_mem[4][8 +: 8]     = 8'd100;
        exp_u[4][1] = 16'd0;
        acc_mem[4][32 +: 16] = 16'd923;
        b_mem[4][16 +: 8]    = 8'd100;
        exp_u[4][2] = 16'd1023;
        u_init[4][48 +: 16]  = 16'hffff;
        exp_u[4][3] = 16'd0;
        u_init[4][64 +: 16]  = 16'd17;
        exp_u[4][4] = 16'd16;

        // Start while reset is held: nothing may move.
        seen_busy = 1'b0;
        seen_done = 1'b0;
        seen_we   = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            seen_busy |= busy;
            seen_done |= done;
            seen_we   |= u_write_sram_we | spk_write_sram_we;
        end
        check("rst_busy", seen_busy, 1'b0);
        check("rst_done", seen_done, 1'b0);
        check("rst_we", seen_we, 1'b0);
        check("rst_addr", u_read_sram_addr, 9'd0);

        @(negedge clk);
        reset = 1'b1;
        load_mems();

        // Full sweep with a stray start at row 40 (RD of row r is cycle 2r+1).
        run_sweep(81, done_cyc, busy_cyc, done_cnt);
        check("done_cycle", done_cyc, 257);
        check("busy_cycles", busy_cyc, 256);
        check("done_count", done_cnt, 1);
        check("u_writes", u_wr_cnt, 128);
        check("spk_writes", spk_wr_cnt, 64);
        check("first_waddr", first_waddr, 0);
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 8; k++)
                check($sformatf("u_r%0d_l%0d", r, k), u_mem[r][16*k +: 16], exp_u[r][k]);
        check("u_row127", u_mem[127], 128'd0);
        check("spk_w0", spk_mem[0], 16'h0108);
`ifdef NEURON_UPDATE_SAT_EN
        check("spk_w1", spk_mem[1], 16'h0100);
`else
        check("spk_w1", spk_mem[1], 16'h0000);
`endif
        check("spk_w2", spk_mem[2], 16'h0002);
        check("spk_w63", spk_mem[63], 16'h0000);

        // Async reset during the WR cycle of row 77.
        spk_init[38] = 16'ha5a5;
        load_mems();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (u_read_sram_addr == 9'd77) break;
            @(negedge clk);
        end
        check("row77_reached", u_read_sram_addr, 9'd77);
        check("row76_we", u_write_sram_we, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_we", u_write_sram_we, 1'b0);
        seen_we = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_we |= u_write_sram_we | spk_write_sram_we;
        end
        check("arst_no_we", seen_we, 1'b0);
        check("arst_u_writes", u_wr_cnt, 77);
        check("arst_spk38", spk_mem[38], 16'ha5a5);
        reset = 1'b1;

        load_mems();
        run_sweep(0, done_cyc, busy_cyc, done_cnt);
        check("re_done_cycle", done_cyc, 257);
        check("re_first_waddr", first_waddr, 0);
        check("re_u_writes", u_wr_cnt, 128);
        check("re_spk_writes", spk_wr_cnt, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
